// File: rtl/led_mode_scheduler_if.sv
// Button, sensor and PWM-driver command signals of the LED mode scheduler.
// The scheduler takes the slave side; the stimulus/button side takes master.
interface led_mode_scheduler_if;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic [9:0]  distancia;
  logic [15:0] parametro;
  logic [3:0]  mode;
  logic [3:0]  parametromanual;
  logic [15:0] duty_cmd;
  logic        lamp_on;

  modport master (
    output btn_mode, btn_up, btn_down, distancia, parametro,
    input  mode, parametromanual, duty_cmd, lamp_on
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, distancia, parametro,
    output mode, parametromanual, duty_cmd, lamp_on
  );
endinterface

// File: rtl/led_mode_scheduler.sv
// Front-end controller for the LED PWM driver: button debouncing, mode FSM,
// manual level, presence/hold-off timing and a per-tick soft brightness ramp.
module led_mode_scheduler #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 5000,
  parameter int NEAR_CM        = 100,
  parameter int RAMP_STEP      = 5,
  parameter int DUTY_MAX       = 495
) (
  input logic sys_clk,
  input logic rst,
  led_mode_scheduler_if.slave bus
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HCW = $clog2(HOLD_TICKS + 1);
  localparam logic [15:0] STEP16 = 16'(RAMP_STEP);
  localparam logic [15:0] MAX16  = 16'(DUTY_MAX);
  localparam logic [15:0] NEAR16 = 16'(NEAR_CM);

  typedef enum logic [1:0] {M_OFF, M_AUTO, M_MANUAL} mode_e;
  typedef enum logic [1:0] {P_IDLE, P_ACTIVE, P_HOLD} pres_e;

  function automatic logic [15:0] ramp_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt);
    logic [15:0] r;
    r = cur;
    if (cur < tgt)
      r = ((tgt - cur) > STEP16) ? (cur + STEP16) : tgt;
    else if (cur > tgt)
      r = ((cur - tgt) > STEP16) ? (cur - STEP16) : tgt;
    return r;
  endfunction

  function automatic logic [15:0] auto_target(input logic [15:0] p);
    logic [15:0] r;
    if (p > 16'd4500) begin
      r = MAX16;
    end else begin
      r = p / 16'd10;
      if (r > MAX16) r = MAX16;
    end
    return r;
  endfunction

  // ---- timebase
  logic [TCW-1:0] tick_cnt;
  logic           tick;

  assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---- button synchronizers and debouncers: bit 0 mode, 1 up, 2 down
  logic [2:0]     btn_raw, sync1, sync2, acc, acc_q, press;
  logic [DBW-1:0] db_cnt [3];
  logic           ev_mode, ev_up, ev_down;

  assign btn_raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      acc_q <= acc;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (tick) begin
          if (db_cnt[i] == DBW'(DEBOUNCE_TICKS - 1)) begin
            acc[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign press   = acc & ~acc_q;
  assign ev_mode = press[0];
  assign ev_up   = press[1];
  assign ev_down = press[2];

  // ---- operating-mode FSM
  mode_e mode_q, mode_d;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) mode_q <= M_OFF;
    else     mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (ev_mode) begin
      case (mode_q)
        M_OFF:   mode_d = M_AUTO;
        M_AUTO:  mode_d = M_MANUAL;
        default: mode_d = M_OFF;
      endcase
    end
  end

  always_comb begin
    case (mode_q)
      M_AUTO:   bus.mode = 4'b0001;
      M_MANUAL: bus.mode = 4'b0010;
      default:  bus.mode = 4'b0000;
    endcase
  end

  // A mode event in the same cycle as up/down wins; the level is left alone.
  logic [3:0] level_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      level_q <= 4'd5;
    end else if (mode_q == M_MANUAL && !ev_mode && (ev_up ^ ev_down)) begin
      if (ev_up && level_q != 4'd9)        level_q <= level_q + 4'd1;
      else if (ev_down && level_q != 4'd0) level_q <= level_q - 4'd1;
    end
  end

  assign bus.parametromanual = level_q;

  // ---- presence FSM with hold-off timer
  pres_e          pres_q, pres_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           near, lamp;

  assign near = ({6'd0, bus.distancia} < NEAR16);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pres_q <= P_IDLE;
      hold_q <= '0;
    end else begin
      pres_q <= pres_d;
      hold_q <= hold_d;
    end
  end

  always_comb begin
    pres_d = pres_q;
    hold_d = hold_q;
    case (pres_q)
      P_IDLE:   if (near) pres_d = P_ACTIVE;
      P_ACTIVE: if (!near) begin
                  pres_d = P_HOLD;
                  hold_d = '0;
                end
      P_HOLD:   if (near) begin
                  pres_d = P_ACTIVE;
                end else if (tick) begin
                  if (hold_q == HCW'(HOLD_TICKS - 1)) pres_d = P_IDLE;
                  else                                hold_d = hold_q + 1'b1;
                end
      default:  pres_d = P_IDLE;
    endcase
  end

  always_comb begin
    lamp = (pres_q != P_IDLE);
    bus.lamp_on = lamp;
  end

  // ---- p1: target duty, p2: ramped duty command
  logic [15:0] target_p1, duty_p2;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      target_p1 <= '0;
      duty_p2   <= '0;
    end else begin
      if (!lamp || mode_q == M_OFF)
        target_p1 <= '0;
      else if (mode_q == M_MANUAL)
        target_p1 <= {12'd0, level_q} * 16'd55;
      else
        target_p1 <= auto_target(bus.parametro);
      if (tick) duty_p2 <= ramp_toward(duty_p2, target_p1);
    end
  end

  assign bus.duty_cmd = duty_p2;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler with a fast timebase and short
// debounce/hold times; steady-state vectors come from a table.
module tb_led_mode_scheduler;
  localparam int TD = 4;
  localparam int DB = 2;
  localparam int HT = 10;
  localparam int RS = 55;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  led_mode_scheduler_if bus_if ();

  led_mode_scheduler #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .HOLD_TICKS(HT),
    .NEAR_CM(100), .RAMP_STEP(RS), .DUTY_MAX(495)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int parametro;
    int distancia;
    int exp_duty;
    int exp_lamp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    bus_if.btn_mode = m;
    bus_if.btn_up   = u;
    bus_if.btn_down = d;
    wait_cycles(16);
    bus_if.btn_mode = 1'b0;
    bus_if.btn_up   = 1'b0;
    bus_if.btn_down = 1'b0;
    wait_cycles(16);
  endtask

  // Waits for duty_cmd to move, then checks the value it moved to.
  task automatic expect_step(input int exp);
    int  prev;
    bit  seen;
    prev = int'(bus_if.duty_cmd);
    seen = 1'b0;
    for (int i = 0; i < 2 * TD + 4; i++) begin
      @(negedge sys_clk);
      if (int'(bus_if.duty_cmd) != prev) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL ramp_step: duty stuck at %0d, expected %0d", prev, exp);
    end else begin
      check("ramp_step", int'(bus_if.duty_cmd), exp);
    end
  endtask

  task automatic wait_duty(input int v, input int max_cycles, input string name);
    int i;
    i = 0;
    while (int'(bus_if.duty_cmd) != v && i < max_cycles) begin
      @(negedge sys_clk);
      i++;
    end
    check(name, int'(bus_if.duty_cmd), v);
  endtask

  initial begin
    int n;
    int min_duty;

    vecs[0] = '{1234,  50, 123, 1};
    vecs[1] = '{0,     99,   0, 1};
    vecs[2] = '{9999,  99, 495, 1};
    vecs[3] = '{4500,  50, 450, 1};
    vecs[4] = '{2000, 100,   0, 0};
    vecs[5] = '{45,     0,   4, 1};
    vecs[6] = '{4600,  10, 495, 1};
    vecs[7] = '{3000, 100,   0, 0};

    rst              = 1'b1;
    bus_if.btn_mode  = 1'b0;
    bus_if.btn_up    = 1'b0;
    bus_if.btn_down  = 1'b0;
    bus_if.distancia = 10'd1000;
    bus_if.parametro = 16'd0;
    wait_cycles(3);
    check("rst_mode",  int'(bus_if.mode), 0);
    check("rst_level", int'(bus_if.parametromanual), 5);
    check("rst_duty",  int'(bus_if.duty_cmd), 0);
    check("rst_lamp",  int'(bus_if.lamp_on), 0);
    rst = 1'b0;
    wait_cycles(2);

    // a one-tick bounce must not be accepted
    bus_if.btn_mode = 1'b1;
    wait_cycles(TD);
    bus_if.btn_mode = 1'b0;
    wait_cycles(24);
    check("bounce_mode", int'(bus_if.mode), 0);

    press(1'b0, 1'b1, 1'b0);
    check("off_up_level", int'(bus_if.parametromanual), 5);
    check("off_up_duty",  int'(bus_if.duty_cmd), 0);

    press(1'b1, 1'b0, 1'b0);
    check("mode_auto", int'(bus_if.mode), 1);

    // AUTO ramp: 3000 -> 300, 4501 -> 495, 4500 -> 450
    bus_if.parametro = 16'd3000;
    bus_if.distancia = 10'd50;
    for (int v = 55; v <= 275; v += 55) expect_step(v);
    expect_step(300);
    wait_cycles(3 * TD);
    check("auto_hold300", int'(bus_if.duty_cmd), 300);
    bus_if.parametro = 16'd4501;
    for (int v = 355; v <= 465; v += 55) expect_step(v);
    expect_step(495);
    bus_if.parametro = 16'd4500;
    expect_step(450);
    wait_cycles(3 * TD);
    check("auto_hold450", int'(bus_if.duty_cmd), 450);

    for (int i = 0; i < 8; i++) begin
      bus_if.parametro = 16'(vecs[i].parametro);
      bus_if.distancia = 10'(vecs[i].distancia);
      wait_cycles(24 * TD);
      check($sformatf("vec%0d_duty", i), int'(bus_if.duty_cmd), vecs[i].exp_duty);
      check($sformatf("vec%0d_lamp", i), int'(bus_if.lamp_on), vecs[i].exp_lamp);
    end

    // MANUAL level handling with the lamp off
    press(1'b1, 1'b0, 1'b0);
    check("mode_manual", int'(bus_if.mode), 2);
    press(1'b0, 1'b1, 1'b0);
    check("level_up1", int'(bus_if.parametromanual), 6);
    for (int i = 0; i < 5; i++) press(1'b0, 1'b1, 1'b0);
    check("level_sat9", int'(bus_if.parametromanual), 9);
    check("manual_dark_duty", int'(bus_if.duty_cmd), 0);
    press(1'b0, 1'b1, 1'b1);
    check("level_updown", int'(bus_if.parametromanual), 9);
    press(1'b0, 1'b0, 1'b1);
    check("level_down", int'(bus_if.parametromanual), 8);
    press(1'b0, 1'b1, 1'b0);
    check("level_up9", int'(bus_if.parametromanual), 9);

    bus_if.distancia = 10'd50;
    for (int v = 55; v <= 495; v += 55) expect_step(v);
    wait_cycles(3 * TD);
    check("manual_hold495", int'(bus_if.duty_cmd), 495);

    // presence lost: lamp holds HOLD_TICKS ticks, then ramp down
    bus_if.distancia = 10'd100;
    n = 0;
    while (bus_if.lamp_on && n < 15 * TD) begin
      @(negedge sys_clk);
      n++;
    end
    n_tests++;
    if (n < 9 * TD + 1 || n > 10 * TD + 2) begin
      n_fail++;
      $display("FAIL hold_len: lamp fell after %0d cycles, expected %0d..%0d",
               n, 9 * TD + 1, 10 * TD + 2);
    end
    check("hold_duty", int'(bus_if.duty_cmd), 495);
    for (int v = 440; v >= 0; v -= 55) expect_step(v);

    // presence returns mid-hold: no ramp-down at all
    bus_if.distancia = 10'd50;
    wait_duty(495, 20 * TD, "rearm_duty");
    bus_if.distancia = 10'd100;
    wait_cycles(5 * TD);
    check("midhold_lamp", int'(bus_if.lamp_on), 1);
    bus_if.distancia = 10'd99;
    min_duty = int'(bus_if.duty_cmd);
    for (int i = 0; i < 20 * TD; i++) begin
      @(negedge sys_clk);
      if (int'(bus_if.duty_cmd) < min_duty) min_duty = int'(bus_if.duty_cmd);
    end
    check("midhold_min_duty", min_duty, 495);
    check("midhold_lamp_end", int'(bus_if.lamp_on), 1);

    // mode and up in the same cycle: mode advances, level untouched
    press(1'b0, 1'b0, 1'b1);
    check("level_down8", int'(bus_if.parametromanual), 8);
    press(1'b1, 1'b1, 1'b0);
    check("modeup_mode",  int'(bus_if.mode), 0);
    check("modeup_level", int'(bus_if.parametromanual), 8);

    // reset in the middle of an AUTO ramp
    wait_duty(0, 15 * TD, "off_rampdown");
    bus_if.parametro = 16'd9999;
    bus_if.btn_mode  = 1'b1;
    wait_duty(220, 30 * TD, "reach220");
    rst = 1'b1;
    #1;
    check("midramp_rst_duty",  int'(bus_if.duty_cmd), 0);
    check("midramp_rst_mode",  int'(bus_if.mode), 0);
    check("midramp_rst_level", int'(bus_if.parametromanual), 5);
    check("midramp_rst_lamp",  int'(bus_if.lamp_on), 0);
    bus_if.btn_mode = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_scheduler.md
Name: led_mode_scheduler

Overview:
Front-end controller for the LED PWM driver. Turns user buttons, the presence distance reading and the ambient light reading into the driver's mode code, manual level and a ramped duty command. Owns the operating-mode FSM, manual level, presence/hold-off timer and soft brightness ramp. Sits between the button/sensor inputs and the PWM driver, all in the sys_clk domain.

Parameters:
TICK_DIV, 50000, sys_clk cycles per timebase tick (1 ms at 50 MHz)
DEBOUNCE_TICKS, 20, ticks a button must be stable before its new level is accepted
HOLD_TICKS, 5000, ticks the lamp stays on after presence is lost
NEAR_CM, 100, distancia threshold; presence when distancia < NEAR_CM
RAMP_STEP, 5, maximum duty change per tick
DUTY_MAX, 495, full-scale duty code

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_mode  in  1  raw async button; press cycles operating mode
btn_up  in  1  raw async button; manual level +1
btn_down  in  1  raw async button; manual level -1
distancia  in  10  distance reading in cm
parametro  in  16  ambient light reading
mode  out  4  driver mode code: 4'b0000 OFF, 4'b0001 AUTO, 4'b0010 MANUAL
parametromanual  out  4  manual level 0..9
duty_cmd  out  16  ramped duty command, 0..DUTY_MAX
lamp_on  out  1  high while presence FSM is ACTIVE or HOLD

Behaviour:
- Reset (async, rst high): mode=OFF, parametromanual=5, duty_cmd=0, lamp_on=0, presence=IDLE. Tick counter, debouncers and hold counter clear. All outputs are registered.
- Timebase: free-running counter 0..TICK_DIV-1. One-cycle tick pulse when it wraps.
- Buttons:
  - Each button has a 2-FF synchronizer and a debouncer.
  - Debouncer: the synchronized level must differ from the accepted level on DEBOUNCE_TICKS consecutive ticks before the accepted level updates. Any bounce restarts the count.
  - A press event is a one-cycle pulse on the accepted level's rising edge.
- Mode FSM:
  - OFF -> AUTO -> MANUAL -> OFF on each btn_mode press event.
  - mode updates the cycle after the press event.
- Manual level:
  - up +1 saturating at 9; down -1 saturating at 0.
  - Acted on only while mode=MANUAL; ignored in other modes.
  - up and down events in the same cycle: no change.
  - A mode event in the same cycle as an up/down event: mode change applies, level unchanged.
  - Level is retained across mode changes.
- Presence FSM (evaluated every cycle; counts on tick):
  - near = distancia < NEAR_CM (99 is near, 100 is not).
  - IDLE: near -> ACTIVE.
  - ACTIVE: !near -> HOLD, hold counter = 0.
  - HOLD: near -> ACTIVE. Otherwise the counter increments on each tick; reaching HOLD_TICKS -> IDLE.
  - lamp_on = (state != IDLE).
- Target (registered, 1-cycle latency from inputs):
  - lamp_on=0 or mode=OFF -> 0.
  - MANUAL -> level*55 (9 gives 495).
  - AUTO -> DUTY_MAX if parametro > 4500, else parametro/10 (integer divide, floor), clipped to DUTY_MAX.
- Ramp:
  - On each tick, if duty_cmd < target: duty_cmd = min(duty_cmd+RAMP_STEP, target).
  - If duty_cmd > target: duty_cmd = max(duty_cmd-RAMP_STEP, target) with no underflow.
  - Equal: hold.
  - Target changes mid-ramp: ramp reverses immediately toward the new target.
  - Between ticks duty_cmd holds.
- Reset mid-ramp or mid-hold: all state returns to reset values at once. No ramp-down occurs.
- Widths: all arithmetic is done at 16 bits. The level*55 product fits in 9 bits and is zero-extended.

Test Plan:
Sim parameters for all scenarios: TICK_DIV=4, DEBOUNCE_TICKS=2, HOLD_TICKS=10, RAMP_STEP=55.
- Reset, then btn_mode held 3 ticks -> mode goes 0000 to 0001 exactly once. A bounce pulse (1 tick wide) produces no mode change.
- Enter MANUAL (2 presses), distancia=50: up x6 -> parametromanual saturates at 9; duty_cmd climbs 0,55,...,495 in 9 ticks and holds at 495. Simultaneous up+down -> level stays 9.
- MANUAL level 9 at 495, distancia=100 -> lamp_on stays 1 for 10 ticks, then 0. duty_cmd ramps to 0 over 9 ticks. distancia=99 at hold tick 5 -> back to ACTIVE, no ramp-down.
- AUTO, near, parametro=3000 -> target 300; duty_cmd 0,55,...,275,300. parametro=4501 -> ramps to 495. parametro=4500 -> ramps back to 450.
- MANUAL with up press while mode=OFF -> level unchanged (5), duty_cmd 0. Mode press and up press in the same cycle -> mode advances, level unchanged.
- Assert rst mid-ramp (duty_cmd=220) -> same cycle asynchronously: duty_cmd=0, mode=0000, parametromanual=5, lamp_on=0.
